// File: rtl/gate_truth_table_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gate_truth_table_scanner                                                  |
// | N-input gate with selectable function, a registered direct path and a     |
// | sweep engine that captures the complete truth table.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gate_truth_table_scanner #(
  parameter int N_INPUTS = 3,
  parameter int TT_W     = 2 ** N_INPUTS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          i_mode,
  input  logic                i_ext_en,
  input  logic [N_INPUTS-1:0] i_ext_in,
  output logic                o_s,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic [N_INPUTS-1:0] o_idx,
  output logic [TT_W-1:0]     o_table_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [N_INPUTS-1:0] c_LAST_IDX = {N_INPUTS{1'b1}};

  logic [1:0]          r_state;
  logic [2:0]          r_mode_q;
  logic                r_s;
  logic                r_busy;
  logic                r_done;
  logic [N_INPUTS-1:0] r_idx;
  logic [TT_W-1:0]     r_table;

  logic                w_ext_result;
  logic                w_scan_result;

  // Reserved encodings (6, 7) evaluate to 0.
  function automatic logic gate_fn(input logic [2:0] m, input logic [N_INPUTS-1:0] v);
    logic r;
    r = 1'b0;
    case (m)
      3'd0:    r = ~|v;
      3'd1:    r = |v;
      3'd2:    r = ~&v;
      3'd3:    r = &v;
      3'd4:    r = ^v;
      3'd5:    r = ~^v;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign w_ext_result  = gate_fn(i_mode, i_ext_in);
  assign w_scan_result = gate_fn(r_mode_q, r_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= 1'b0;
    end else if (i_ext_en) begin
      r_s <= w_ext_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mode_q <= 3'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_idx    <= '0;
      r_table  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode_q <= i_mode;
            r_idx    <= '0;
            r_table  <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_table[r_idx] <= w_scan_result;
          // idx parks on the last combination instead of wrapping.
          if (r_idx == c_LAST_IDX) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_s         = r_s;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_idx       = r_idx;
  assign o_table_out = r_table;

endmodule
`default_nettype wire

// File: tb/tb_gate_truth_table_scanner.sv
`default_nettype none
// Testbench for gate_truth_table_scanner: N_INPUTS=3 and N_INPUTS=2 instances.
module tb_gate_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic       ext_en;
  logic [2:0] ext_in3;
  logic [1:0] ext_in2;
  logic       start;
  logic       sel;

  logic       s3, busy3, done3;
  logic [2:0] idx3;
  logic [7:0] tab3;
  logic       s2, busy2, done2;
  logic [1:0] idx2;
  logic [3:0] tab2;

  logic       w_busy, w_done;
  logic [7:0] w_tab;
  logic [2:0] w_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_truth_table_scanner #(.N_INPUTS(3)) u_dut3 (
    .clk(clk), .rst(rst), .i_mode(mode), .i_ext_en(ext_en), .i_ext_in(ext_in3),
    .o_s(s3), .i_start(start & ~sel), .o_busy(busy3), .o_done(done3),
    .o_idx(idx3), .o_table_out(tab3));

  gate_truth_table_scanner #(.N_INPUTS(2)) u_dut2 (
    .clk(clk), .rst(rst), .i_mode(mode), .i_ext_en(ext_en), .i_ext_in(ext_in2),
    .o_s(s2), .i_start(start & sel), .o_busy(busy2), .o_done(done2),
    .o_idx(idx2), .o_table_out(tab2));

  assign w_busy = sel ? busy2 : busy3;
  assign w_done = sel ? done2 : done3;
  assign w_tab  = sel ? {4'h0, tab2} : tab3;
  assign w_idx  = sel ? {1'b0, idx2} : idx3;

  typedef struct {
    logic [2:0] mode;
    logic       en;
    logic [2:0] in;
    logic       exp_s;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full sweep on the selected instance with optional mid-sweep disturbances.
  task automatic sweep(input logic s, input logic [2:0] m, input logic [7:0] exp_tab,
                       input int exp_busy, input logic chg, input logic rep);
    int cnt;
    int dn;
    logic saw_busy;
    sel   = s;
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 0;
    dn    = 0;
    while (w_busy && cnt < 40) begin
      cnt++;
      if (w_done) dn++;
      if (chg && cnt == 2) mode = 3'd3;
      start = rep && (cnt == 3);
      @(negedge clk);
    end
    start = 1'b0;
    check("sweep_busy_cycles", cnt, exp_busy);
    check("sweep_done_high", w_done, 1'b1);
    check("sweep_table", w_tab, exp_tab);
    check("sweep_idx_last", w_idx, exp_busy - 1);
    if (w_done) dn++;
    saw_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (w_done) dn++;
      if (w_busy) saw_busy = 1'b1;
    end
    check("sweep_one_done", dn, 1);
    check("sweep_no_restart", saw_busy, 1'b0);
    check("sweep_table_stable", w_tab, exp_tab);
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{3'd0, 1'b1, 3'b000, 1'b1};
    vecs[1]  = '{3'd0, 1'b1, 3'b010, 1'b0};
    vecs[2]  = '{3'd0, 1'b0, 3'b000, 1'b0};
    vecs[3]  = '{3'd1, 1'b1, 3'b000, 1'b0};
    vecs[4]  = '{3'd1, 1'b1, 3'b100, 1'b1};
    vecs[5]  = '{3'd2, 1'b1, 3'b111, 1'b0};
    vecs[6]  = '{3'd2, 1'b1, 3'b011, 1'b1};
    vecs[7]  = '{3'd3, 1'b1, 3'b110, 1'b0};
    vecs[8]  = '{3'd3, 1'b1, 3'b111, 1'b1};
    vecs[9]  = '{3'd0, 1'b0, 3'b111, 1'b1};
    vecs[10] = '{3'd4, 1'b1, 3'b110, 1'b0};
    vecs[11] = '{3'd4, 1'b1, 3'b111, 1'b1};
    vecs[12] = '{3'd5, 1'b1, 3'b101, 1'b1};
    vecs[13] = '{3'd5, 1'b1, 3'b001, 1'b0};
    vecs[14] = '{3'd6, 1'b1, 3'b111, 1'b0};
    vecs[15] = '{3'd7, 1'b1, 3'b000, 1'b0};

    rst = 1'b1; mode = 3'd0; ext_en = 1'b0; ext_in3 = '0; ext_in2 = '0;
    start = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_s3", s3, 1'b0);
    check("reset_busy3", busy3, 1'b0);
    check("reset_done3", done3, 1'b0);
    check("reset_idx3", idx3, 3'd0);
    check("reset_table3", tab3, 8'h00);
    check("reset_busy2", busy2, 1'b0);
    check("reset_table2", tab2, 4'h0);
    rst = 1'b0;
    @(negedge clk);

    // Direct path
    foreach (vecs[i]) begin
      mode = vecs[i].mode; ext_en = vecs[i].en; ext_in3 = vecs[i].in;
      @(negedge clk);
      check($sformatf("direct_vec%0d", i), s3, vecs[i].exp_s);
    end
    ext_en = 1'b0;

    // Sweeps on the 3-input instance
    sweep(1'b0, 3'd0, 8'h01, 8, 1'b0, 1'b0);
    sweep(1'b0, 3'd2, 8'h7F, 8, 1'b0, 1'b0);
    sweep(1'b0, 3'd4, 8'h96, 8, 1'b0, 1'b0);
    sweep(1'b0, 3'd4, 8'h96, 8, 1'b1, 1'b0);
    sweep(1'b0, 3'd1, 8'hFE, 8, 1'b0, 1'b1);

    // Reset during SCAN aborts the sweep with no done
    sel = 1'b0; mode = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy3, 1'b0);
    check("abort_idx", idx3, 3'd0);
    check("abort_table", tab3, 8'h00);
    check("abort_done", done3, 1'b0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done3 || busy3) cnt++;
    end
    check("abort_quiet", cnt, 0);
    sweep(1'b0, 3'd0, 8'h01, 8, 1'b0, 1'b0);

    // start held high: new sweep on the first IDLE cycle after DONE
    sel = 1'b0; mode = 3'd5; start = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (busy3 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("held_busy_cycles", cnt, 8);
    check("held_done", done3, 1'b1);
    check("held_table", tab3, 8'h69);
    @(negedge clk);
    check("held_idle_gap_busy", busy3, 1'b0);
    check("held_idle_gap_done", done3, 1'b0);
    @(negedge clk);
    check("held_restart_busy", busy3, 1'b1);
    check("held_restart_cleared", tab3, 8'h00);
    check("held_restart_idx", idx3, 3'd0);
    start = 1'b0;
    cnt = 0;
    while ((busy3 || done3) && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("held_drain", cnt < 40, 1'b1);

    // Two-input instance
    sweep(1'b1, 3'd3, 8'h08, 4, 1'b0, 1'b0);
    sweep(1'b1, 3'd6, 8'h00, 4, 1'b0, 1'b0);
    mode = 3'd3; ext_en = 1'b1; ext_in2 = 2'b11;
    @(negedge clk);
    check("direct2_and", s2, 1'b1);
    mode = 3'd6;
    @(negedge clk);
    check("direct2_reserved", s2, 1'b0);
    ext_en = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gate_truth_table_scanner.md
Name: gate_truth_table_scanner

Overview:
- Parametrised N-input logic gate unit with a run-time selectable function. Generalises the fixed 3-input NOR cell.
- Two paths:
  - Direct path: a registered gate output driven from external inputs.
  - Built-in sweep engine: on request, steps through all 2^N input combinations, one per clock, and captures the full truth table into a register.
- Used as a self-checking gate primitive in the practice-lab designs.

Parameters:
- N_INPUTS, 3, number of gate inputs; legal range 1..6.
- TT_W, 2**N_INPUTS, truth-table width; derived, do not override.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  3  gate function select: 0 NOR, 1 OR, 2 NAND, 3 AND, 4 XOR, 5 XNOR, 6/7 reserved (result 0).
- ext_en  in  1  direct-path load enable.
- ext_in  in  N_INPUTS  direct-path gate inputs.
- s  out  1  registered direct-path gate result.
- start  in  1  sweep request; level sampled each clock.
- busy  out  1  high while the sweep is running.
- done  out  1  one-cycle pulse when the sweep completes.
- idx  out  N_INPUTS  current sweep combination index.
- table_out  out  TT_W  captured truth table; bit k = f(mode_q, k).

Behaviour:
- Reset (rst=1 at a clk edge): s=0, busy=0, done=0, idx=0, table_out=0, mode_q=0, state=IDLE. Reset has priority over all other inputs, including mid-sweep; a sweep aborted by reset is discarded and produces no done.
- Gate function f(m, v):
  - v is an N_INPUTS vector.
  - NOR = ~|v, OR = |v, NAND = ~&v, AND = &v, XOR = ^v, XNOR = ~^v, reserved = 0.
  - Input 0 of the gate is the vector MSB (v[N_INPUTS-1]); the reduction is symmetric, so only sweep indexing depends on this.
- Direct path, independent of sweep state:
  - On each edge with ext_en=1: s <= f(mode, ext_in).
  - With ext_en=0, s holds.
  - Latency: 1 clock.
- Sweep FSM, states IDLE, SCAN, DONE:
  - IDLE, start=1:
    - mode_q <= mode, idx <= 0, table_out <= 0, busy <= 1.
    - Go to SCAN.
  - IDLE, start=0: stay; outputs hold.
  - SCAN, each edge:
    - table_out[idx] <= f(mode_q, idx).
    - If idx == TT_W-1: busy <= 0, done <= 1, go to DONE, idx holds at TT_W-1.
    - Else: idx <= idx+1.
  - DONE:
    - done is high for exactly this one cycle.
    - Next edge: done <= 0, go to IDLE.
- Timing: start sampled at edge T gives busy=1 for exactly TT_W cycles (edges T+1..T+TT_W), and done=1 during the cycle after edge T+TT_W. A full sweep occupies TT_W+2 cycles from start to the next IDLE.
- Boundary conditions:
  - start while in SCAN or DONE is ignored; no re-arm and no queuing.
  - start held high continuously restarts a new sweep on the first IDLE cycle after DONE.
  - mode changes during SCAN do not affect the sweep (mode_q is latched); they do affect the direct path immediately.
  - table_out is stable and valid from the done cycle until the next accepted start, which clears it.
  - For N_INPUTS=1, TT_W=2 and the sweep takes 2 SCAN cycles.
  - idx does not wrap during SCAN; it wraps to 0 only on the next accepted start.
- Width rules: idx is exactly N_INPUTS bits, and the compare against TT_W-1 is an all-ones compare. No other arithmetic.

Test Plan:
- N_INPUTS=3, mode=0 (NOR), start pulse -> busy high 8 cycles, done pulse 1 cycle, table_out=8'h01.
- N_INPUTS=3, mode=2 (NAND), then mode=4 (XOR) -> table_out=8'h7F, then 8'h96. Change mode to 3 mid-sweep -> XOR result 8'h96 unchanged.
- Direct path, mode=0: ext_en=1, ext_in=3'b000 -> s=1 one clock later. ext_in=3'b010 -> s=0. Then ext_en=0 with ext_in=3'b000 -> s holds 0.
- start re-pulsed at SCAN cycle 3 -> ignored; done occurs at the original time; exactly one done pulse.
- rst asserted at SCAN cycle 4 -> next edge busy=0, idx=0, table_out=0, no done. A following start runs a clean sweep.
- N_INPUTS=2, mode=3 (AND) -> busy 4 cycles, table_out=4'h8. mode=6 (reserved) -> table_out=4'h0, s=0 on direct path.
